// File: rtl/param_pattern_detector.sv
// param_pattern_detector
// Serial bit-stream pattern detector with a run-time loadable pattern and
// don't-care mask, plus selectable overlapping or non-overlapping detection.
// The newest bit enters at the LSB of the history register. The pattern MSB
// is therefore the first bit of the sequence on the wire.
// Build option: define MATCH_COUNT_EN to include the saturating match counter.
// When it is left undefined, match_count and count_sat are tied to zero.
module param_pattern_detector #(
    parameter int               PAT_W     = 4,
    parameter int               CNT_W     = 8,
    parameter logic [PAT_W-1:0] RESET_PAT = 4'b1011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    input  logic             overlap,
    output logic             detected,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int                FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  r_shreg;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-1:0]  r_mask;
    logic              r_ovl;
    logic              r_detected;

    logic [PAT_W-1:0]  w_nxt;
    logic [FILL_W-1:0] w_fill_inc;
    logic [PAT_W-1:0]  w_bit_ok;
    logic              w_match;

    // Per-bit compare: a masked-off position always agrees.
    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign w_bit_ok[gi] = ~r_mask[gi] | (w_nxt[gi] ~^ r_pat[gi]);
        end
    endgenerate

    // Candidate history and fill for this edge, and the match decision.
    always_comb begin
        w_nxt      = {r_shreg[PAT_W-2:0], din};
        w_fill_inc = (r_fill == FULL) ? FULL : r_fill + 1'b1;
        w_match    = din_valid && !load && (w_fill_inc == FULL) && (&w_bit_ok);
    end

    // History, fill, configuration and detect pulse. Reset beats load, and load beats data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg    <= '0;
            r_fill     <= '0;
            r_pat      <= RESET_PAT;
            r_mask     <= '1;
            r_ovl      <= 1'b1;
            r_detected <= 1'b0;
        end else if (load) begin
            r_pat      <= pattern;
            r_mask     <= mask;
            r_ovl      <= overlap;
            r_shreg    <= '0;
            r_fill     <= '0;
            r_detected <= 1'b0;
        end else if (din_valid) begin
            r_shreg    <= w_nxt;
            // In non-overlapping mode a hit consumes the whole window.
            r_fill     <= (w_match && !r_ovl) ? '0 : w_fill_inc;
            r_detected <= w_match;
        end else begin
            r_detected <= 1'b0;
        end
    end

    assign detected = r_detected;

`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] r_count;

    // Saturating hit counter. It is cleared whenever the search restarts.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_count <= '0;
        end else if (w_match && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign match_count = r_count;
    assign count_sat   = &r_count;
`else
    assign match_count = '0;
    assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_param_pattern_detector.sv
// Directed testbench for param_pattern_detector (PAT_W=4, CNT_W=2).
// Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled at the same point, after the edge that consumed the inputs.
module tb_param_pattern_detector;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
`ifdef MATCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             din_valid;
    logic             din;
    logic             load;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] mask;
    logic             overlap;
    logic             detected;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    int n_tests = 0;
    int n_fail  = 0;

    param_pattern_detector #(
        .PAT_W    (PAT_W),
        .CNT_W    (CNT_W),
        .RESET_PAT(4'b1011)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .load       (load),
        .pattern    (pattern),
        .mask       (mask),
        .overlap    (overlap),
        .detected   (detected),
        .match_count(match_count),
        .count_sat  (count_sat)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic v);
        din       = b;
        din_valid = v;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic do_reset(input logic v, input logic b);
        reset     = 1'b1;
        din_valid = v;
        din       = b;
        tick();
        reset     = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] p, input logic [3:0] m, input logic o,
                           input logic v, input logic b);
        load      = 1'b1;
        pattern   = p;
        mask      = m;
        overlap   = o;
        din_valid = v;
        din       = b;
        tick();
        load      = 1'b0;
        din_valid = 1'b0;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    logic [15:0] stream;
    logic [15:0] exp_ov;
    logic [15:0] exp_no;
    logic [15:0] sat_stream;
    logic [7:0]  mstream;

    initial begin
        stream     = 16'b1011010110111100;
        exp_ov     = 16'b0001000010010000;   // hits after bits 4, 9, 12
        exp_no     = 16'b0001000010000000;   // hits after bits 4, 9
        sat_stream = 16'b1011011011011011;   // five overlapping hits
        mstream    = 8'b1111_1101;
        reset = 1'b1; din_valid = 1'b0; din = 1'b0; load = 1'b0;
        pattern = '0; mask = '0; overlap = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_det", 32'(detected), 32'd0);
        check("reset_cnt", 32'(match_count), 32'd0);
        check("reset_sat", 32'(count_sat), 32'd0);

        // Overlapping search with the reset pattern.
        for (int i = 0; i < 16; i++) begin
            send(stream[15-i], 1'b1);
            check($sformatf("ovl_bit%0d", i + 1), 32'(detected), 32'(exp_ov[15-i]));
        end
        check("ovl_cnt", 32'(match_count), exp_cnt(3));

        // Non-overlapping search on the same stream.
        do_load(4'b1011, 4'b1111, 1'b0, 1'b0, 1'b0);
        check("load_cnt_clr", 32'(match_count), 32'd0);
        for (int i = 0; i < 16; i++) begin
            send(stream[15-i], 1'b1);
            check($sformatf("novl_bit%0d", i + 1), 32'(detected), 32'(exp_no[15-i]));
        end
        check("novl_cnt", 32'(match_count), exp_cnt(2));

        // Masked search 1xx1, non-overlapping. The middle bits are don't-care.
        do_load(4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(mstream[7-i], 1'b1);
            check($sformatf("mask_bit%0d", i + 1), 32'(detected), 32'((i == 3) || (i == 7)));
        end

        // An all-zero mask matches every valid bit once the window is full.
        do_load(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send(i[0], 1'b1);
            check($sformatf("mask0_bit%0d", i + 1), 32'(detected), 32'(i >= 3));
        end

        // Valid gaps: three idle cycles between data bits, with din toggling.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send(stream[15-k], 1'b1);
            check($sformatf("gap_bit%0d", k + 1), 32'(detected), 32'(k == 3));
            for (int g = 0; g < 3; g++) begin
                send(g[0] ^ 1'b1, 1'b0);
                check($sformatf("gap_idle%0d_%0d", k + 1, g), 32'(detected), 32'd0);
            end
        end

        // A mid-stream reset discards 101. Reset also wins over a valid bit in the same cycle.
        do_reset(1'b0, 1'b0);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b1, 1'b1);
        do_reset(1'b1, 1'b1);
        check("rst_mid_det", 32'(detected), 32'd0);
        send(1'b1, 1'b1);
        check("rst_mid_after", 32'(detected), 32'd0);

        // Load clears a pending detect pulse. The data bit in the load cycle is dropped.
        do_reset(1'b0, 1'b0);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        check("pre_load_det", 32'(detected), 32'd1);
        do_load(4'b1011, 4'b1111, 1'b1, 1'b1, 1'b1);
        check("load_det_clr", 32'(detected), 32'd0);
        send(1'b0, 1'b1);
        check("load_drop_b1", 32'(detected), 32'd0);
        send(1'b1, 1'b1);
        check("load_drop_b2", 32'(detected), 32'd0);
        send(1'b1, 1'b1);
        check("load_drop_b3", 32'(detected), 32'd0);

        // Saturation: five hits into a 2-bit counter.
        do_load(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send(sat_stream[15-i], 1'b1);
        end
        check("sat_cnt", 32'(match_count), exp_cnt(3));
        check("sat_flag", 32'(count_sat), 32'(CNT_EN));
        do_load(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0);
        check("sat_clr_cnt", 32'(match_count), 32'd0);
        check("sat_clr_flag", 32'(count_sat), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
